// File: rtl/mux_pkg.sv
// Shared widths, select codes and the sample bundle for the registered 4-to-1 mux.
package mux_pkg;

    localparam int SEL_W = 2;
    localparam int N_IN  = 4;

    localparam logic [SEL_W-1:0] SEL_I0 = 2'b00;
    localparam logic [SEL_W-1:0] SEL_I1 = 2'b01;
    localparam logic [SEL_W-1:0] SEL_I2 = 2'b10;
    localparam logic [SEL_W-1:0] SEL_I3 = 2'b11;

    // One sample as presented on the input side: truth-table column plus variables.
    typedef struct packed {
        logic [N_IN-1:0]  data;
        logic [SEL_W-1:0] sel;
    } mux_req_t;

endpackage

// File: rtl/decoder_2x4.sv
// Combinational 2-to-4 one-hot decoder; every select code drives exactly one line.
module decoder_2x4
    import mux_pkg::*;
(
    input  logic [SEL_W-1:0] s,
    output logic [N_IN-1:0]  d
);

    always_comb begin
        d = '0;
        unique case (s)
            SEL_I0: d = 4'b0001;
            SEL_I1: d = 4'b0010;
            SEL_I2: d = 4'b0100;
            SEL_I3: d = 4'b1000;
            default: d = '0;
        endcase
    end

endmodule

// File: rtl/mux_4_to_1.sv
// Registered 4-to-1 single-bit mux: one-hot decode, AND-OR select, one-cycle output register.
module mux_4_to_1
    import mux_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  i,
    input  logic [SEL_W-1:0] s,
    input  logic             in_valid,
    output logic             F,
    output logic             out_valid,
    output logic [N_IN-1:0]  onehot
);

    mux_req_t        req;
    logic [N_IN-1:0] dec;
    logic [N_IN-1:0] gated;
    logic            sel;
    logic [1:0]      vld_pipe;

    assign req.data = i;
    assign req.sel  = s;

    decoder_2x4 u_dec (
        .s (req.sel),
        .d (dec)
    );

    // Each decoder line gates its own data bit; the OR reduction yields i[s].
    for (genvar k = 0; k < N_IN; k++) begin : g_gate
        assign gated[k] = dec[k] & req.data[k];
    end

    assign sel         = |gated;
    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F           <= RESET_VAL;
            onehot      <= '0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                F      <= sel;
                onehot <= dec;
            end
        end
    end

    assign out_valid = vld_pipe[1];

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed bench for mux_4_to_1: reset, per-select capture, hold, reset mid-stream, full sweep.
module tb_mux_4_to_1;

    logic       clk;
    logic       rst_n;
    logic [3:0] i;
    logic [1:0] s;
    logic       in_valid;
    logic       F;
    logic       out_valid;
    logic [3:0] onehot;

    int checks = 0;
    int errors = 0;

    mux_4_to_1 #(.RESET_VAL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i),
        .s         (s),
        .in_valid  (in_valid),
        .F         (F),
        .out_valid (out_valid),
        .onehot    (onehot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive on the falling edge, let the rising edge capture, settle 1 time unit.
    task automatic drive(input logic r, input logic v, input logic [1:0] sv, input logic [3:0] iv);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        s        = sv;
        i        = iv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 2'b11, 4'b1111);
        drive(1'b0, 1'b1, 2'b11, 4'b1111);
        checks++;
        if (F !== 1'b0) begin
            errors++;
            $display("FAIL reset_F got %b want 0", F);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (onehot !== 4'b0000) begin
            errors++;
            $display("FAIL reset_onehot got %b want 0000", onehot);
        end
    endtask

    task automatic test_select(input logic [1:0] sv, input logic [3:0] hot, input logic [3:0] cold);
        drive(1'b1, 1'b1, sv, hot);
        checks++;
        if (F !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL select_hot s=%0d F/out_valid got %b%b want 11", sv, F, out_valid);
        end
        checks++;
        if (onehot !== hot) begin
            errors++;
            $display("FAIL select_onehot s=%0d got %b want %b", sv, onehot, hot);
        end
        drive(1'b1, 1'b1, sv, cold);
        checks++;
        if (F !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL select_cold s=%0d F/out_valid got %b%b want 01", sv, F, out_valid);
        end
        checks++;
        if (onehot !== hot) begin
            errors++;
            $display("FAIL select_onehot2 s=%0d got %b want %b", sv, onehot, hot);
        end
    endtask

    task automatic test_hold_reset();
        drive(1'b1, 1'b1, 2'b10, 4'b0100);
        checks++;
        if (F !== 1'b1) begin
            errors++;
            $display("FAIL hold_capture got %b want 1", F);
        end
        drive(1'b1, 1'b0, 2'b00, 4'b0000);
        checks++;
        if (F !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle F/out_valid got %b%b want 10", F, out_valid);
        end
        checks++;
        if (onehot !== 4'b0100) begin
            errors++;
            $display("FAIL hold_onehot got %b want 0100", onehot);
        end
        drive(1'b1, 1'b0, 2'b11, 4'b1000);
        checks++;
        if (F !== 1'b1 || onehot !== 4'b0100) begin
            errors++;
            $display("FAIL hold_idle2 F/onehot got %b %b want 1 0100", F, onehot);
        end
        // Sample presented during reset must be discarded.
        drive(1'b0, 1'b1, 2'b11, 4'b1000);
        checks++;
        if (F !== 1'b0 || out_valid !== 1'b0 || onehot !== 4'b0000) begin
            errors++;
            $display("FAIL midreset got F=%b ov=%b oh=%b want 0 0 0000", F, out_valid, onehot);
        end
        drive(1'b1, 1'b0, 2'b11, 4'b1000);
        checks++;
        if (F !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset F/out_valid got %b%b want 00", F, out_valid);
        end
    endtask

    task automatic test_unselected();
        logic [3:0] pats [4] = '{4'b0010, 4'b1111, 4'b0011, 4'b1010};
        foreach (pats[n]) begin
            drive(1'b1, 1'b1, 2'b01, pats[n]);
            checks++;
            if (F !== 1'b1) begin
                errors++;
                $display("FAIL unselected n=%0d i=%b got %b want 1", n, pats[n], F);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] iv;
        logic [1:0] sv;
        logic       exp_f;
        logic [3:0] exp_oh;
        for (int v = 0; v < 64; v++) begin
            sv     = v[5:4];
            iv     = v[3:0];
            exp_f  = iv[sv];
            exp_oh = 4'b0001 << sv;
            drive(1'b1, 1'b1, sv, iv);
            checks++;
            if (F !== exp_f || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep s=%0d i=%b F/ov got %b%b want %b1", sv, iv, F, out_valid, exp_f);
            end
            checks++;
            if (onehot !== exp_oh) begin
                errors++;
                $display("FAIL sweep_onehot s=%0d got %b want %b", sv, onehot, exp_oh);
            end
        end
        drive(1'b1, 1'b0, 2'b00, 4'b0000);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end_out_valid got %b want 0", out_valid);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        s        = 2'b00;
        i        = 4'b0000;
        test_reset();
        test_select(2'b00, 4'b0001, 4'b1110);
        test_select(2'b01, 4'b0010, 4'b1101);
        test_select(2'b10, 4'b0100, 4'b1011);
        test_select(2'b11, 4'b1000, 4'b0111);
        test_hold_reset();
        test_unselected();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
